// File: rtl/pipeline_stage_register.sv
// Inter-stage pipeline register (D->E, E->M, M->W): DEPTH stages of {valid, ctrl, data}, latency DEPTH cycles.
// Stall holds every stage; flush invalidates every stage and outranks stall; saturating stall/bubble counters.
module pipeline_stage_register #(
   parameter int CTRL_W              = 16,
   parameter int DATA_W              = 192,
   parameter int DEPTH               = 1,
   parameter int CLEAR_DATA_ON_FLUSH = 0,
   parameter int CNT_W               = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              StallIn,
   input  logic              FlushIn,
   input  logic              ValidIn,
   input  logic [CTRL_W-1:0] CtrlIn,
   input  logic [DATA_W-1:0] DataIn,
   output logic              ValidOut,
   output logic [CTRL_W-1:0] CtrlOut,
   output logic [DATA_W-1:0] DataOut,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  BubbleCount
);

   if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
      $error("pipeline_stage_register: DEPTH must be in 1..4");
   end

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } stage_t;

   stage_t            stg [DEPTH];
   stage_t            stage_in;
   logic              stall_evt;
   logic              bubble_evt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   // An invalid entry never carries control, so a bubble cannot write regs or memory.
   always_comb begin
      stage_in.valid = ValidIn;
      stage_in.ctrl  = ValidIn ? CtrlIn : '0;
      stage_in.data  = DataIn;
   end

   assign stall_evt  = StallIn & ~FlushIn;
   assign bubble_evt = FlushIn | (~StallIn & ~ValidIn);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg[i] <= '0;
         end
      end else if (FlushIn) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg[i].valid <= 1'b0;
            stg[i].ctrl  <= '0;
            if (CLEAR_DATA_ON_FLUSH != 0) begin
               stg[i].data <= '0;
            end
         end
      end else if (!StallIn) begin
         stg[0] <= stage_in;
         for (int i = 1; i < DEPTH; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (bubble_evt && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end

   assign ValidOut    = stg[DEPTH-1].valid;
   assign CtrlOut     = stg[DEPTH-1].ctrl;
   assign DataOut     = stg[DEPTH-1].data;
   assign StallCount  = stall_cnt;
   assign BubbleCount = bubble_cnt;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: five instances with different DEPTH/flush/counter settings share one
// input stream and are compared against a queue-based reference model plus directed constant expectations.
module tb_pipeline_stage_register;
   localparam int NDUT = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, StallIn, FlushIn, ValidIn;
   logic [15:0] CtrlIn;
   logic [31:0] DataIn;

   logic        v0, v1, v2, v3, v4;
   logic [15:0] c0, c1, c2, c3, c4;
   logic [31:0] d0, d1, d2, d3, d4;
   logic [15:0] s0, s1, s2, s3, b0, b1, b2, b3;
   logic [3:0]  s4, b4;

   pipeline_stage_register #(.CTRL_W(16), .DATA_W(32), .DEPTH(1), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .StallIn(StallIn), .FlushIn(FlushIn), .ValidIn(ValidIn), .CtrlIn(CtrlIn),
      .DataIn(DataIn), .ValidOut(v0), .CtrlOut(c0), .DataOut(d0), .StallCount(s0), .BubbleCount(b0));
   pipeline_stage_register #(.CTRL_W(16), .DATA_W(32), .DEPTH(1), .CLEAR_DATA_ON_FLUSH(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .StallIn(StallIn), .FlushIn(FlushIn), .ValidIn(ValidIn), .CtrlIn(CtrlIn),
      .DataIn(DataIn), .ValidOut(v1), .CtrlOut(c1), .DataOut(d1), .StallCount(s1), .BubbleCount(b1));
   pipeline_stage_register #(.CTRL_W(16), .DATA_W(32), .DEPTH(2), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .StallIn(StallIn), .FlushIn(FlushIn), .ValidIn(ValidIn), .CtrlIn(CtrlIn),
      .DataIn(DataIn), .ValidOut(v2), .CtrlOut(c2), .DataOut(d2), .StallCount(s2), .BubbleCount(b2));
   pipeline_stage_register #(.CTRL_W(16), .DATA_W(32), .DEPTH(3), .CLEAR_DATA_ON_FLUSH(1), .CNT_W(16)) u3 (
      .clk(clk), .rst(rst), .StallIn(StallIn), .FlushIn(FlushIn), .ValidIn(ValidIn), .CtrlIn(CtrlIn),
      .DataIn(DataIn), .ValidOut(v3), .CtrlOut(c3), .DataOut(d3), .StallCount(s3), .BubbleCount(b3));
   pipeline_stage_register #(.CTRL_W(16), .DATA_W(32), .DEPTH(4), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(4)) u4 (
      .clk(clk), .rst(rst), .StallIn(StallIn), .FlushIn(FlushIn), .ValidIn(ValidIn), .CtrlIn(CtrlIn),
      .DataIn(DataIn), .ValidOut(v4), .CtrlOut(c4), .DataOut(d4), .StallCount(s4), .BubbleCount(b4));

   int passed = 0;
   int total  = 0;

   function automatic int dep(int k);
      case (k)
         0, 1:    return 1;
         2:       return 2;
         3:       return 3;
         default: return 4;
      endcase
   endfunction
   function automatic bit clr(int k);
      return (k == 1) || (k == 3);
   endfunction
   function automatic int unsigned cmax(int k);
      return (k == 4) ? 15 : 65535;
   endfunction

   function automatic logic act_v(int k);
      case (k) 0: return v0; 1: return v1; 2: return v2; 3: return v3; default: return v4; endcase
   endfunction
   function automatic logic [15:0] act_c(int k);
      case (k) 0: return c0; 1: return c1; 2: return c2; 3: return c3; default: return c4; endcase
   endfunction
   function automatic logic [31:0] act_d(int k);
      case (k) 0: return d0; 1: return d1; 2: return d2; 3: return d3; default: return d4; endcase
   endfunction
   function automatic logic [15:0] act_s(int k);
      case (k) 0: return s0; 1: return s1; 2: return s2; 3: return s3; default: return {12'h0, s4}; endcase
   endfunction
   function automatic logic [15:0] act_b(int k);
      case (k) 0: return b0; 1: return b1; 2: return b2; 3: return b3; default: return {12'h0, b4}; endcase
   endfunction

   // Reference model: each instance is a queue of in-flight entries, newest at the front.
   typedef struct packed {
      logic        v;
      logic [15:0] c;
      logic [31:0] d;
   } ent_t;

   ent_t        mq  [NDUT][$];
   int unsigned msc [NDUT];
   int unsigned mbc [NDUT];

   function automatic ent_t exp_out(int k);
      return mq[k][mq[k].size()-1];
   endfunction

   task automatic model_cycle();
      for (int k = 0; k < NDUT; k++) begin
         if (rst) begin
            mq[k].delete();
            for (int j = 0; j < dep(k); j++) mq[k].push_back('0);
            msc[k] = 0;
            mbc[k] = 0;
         end else if (FlushIn) begin
            for (int j = 0; j < mq[k].size(); j++) begin
               ent_t e;
               e = mq[k][j];
               e.v = 1'b0;
               e.c = 16'h0;
               if (clr(k)) e.d = 32'h0;
               mq[k][j] = e;
            end
            if (mbc[k] < cmax(k)) mbc[k]++;
         end else if (StallIn) begin
            if (msc[k] < cmax(k)) msc[k]++;
         end else begin
            ent_t e;
            e.v = ValidIn;
            e.c = ValidIn ? CtrlIn : 16'h0;
            e.d = DataIn;
            mq[k].push_front(e);
            void'(mq[k].pop_back());
            if (!ValidIn && mbc[k] < cmax(k)) mbc[k]++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_cycle();
      #1;
   endtask

   task automatic drive(logic r, logic f, logic s, logic v, logic [15:0] c, logic [31:0] d);
      rst = r; FlushIn = f; StallIn = s; ValidIn = v; CtrlIn = c; DataIn = d;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 16'h0, 32'h0);
      tick();
      for (int k = 0; k < NDUT; k++) begin
         total++;
         if ({act_v(k), act_c(k), act_d(k), act_s(k), act_b(k)} !== 81'h0)
            $display("FAIL reset_init k=%0d got v=%0b c=%h d=%h sc=%0d bc=%0d want all 0",
                     k, act_v(k), act_c(k), act_d(k), act_s(k), act_b(k));
         else passed++;
      end
      drive(0, 0, 1, 0, 16'h0, 32'h0);
      tick();
      drive(0, 0, 0, 0, 16'h0, 32'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, 16'h00A5, i);
         tick();
      end
      drive(1, 0, 0, 1, 16'h00A5, 32'd5);
      tick();
      for (int k = 0; k < NDUT; k++) begin
         total++;
         if ({act_v(k), act_c(k), act_d(k), act_s(k), act_b(k)} !== 81'h0)
            $display("FAIL reset_midstream k=%0d got v=%0b c=%h d=%h sc=%0d bc=%0d want all 0",
                     k, act_v(k), act_c(k), act_d(k), act_s(k), act_b(k));
         else passed++;
      end
   endtask

   task automatic test_latency();
      drive(1, 0, 0, 0, 16'h0, 32'h0);
      tick();
      drive(0, 0, 0, 1, 16'h0C3A, 32'hDEAD_BEEF);
      for (int t = 1; t <= 5; t++) begin
         tick();
         drive(0, 0, 0, 0, 16'h0, 32'h0);
         for (int k = 0; k < NDUT; k++) begin
            logic        ev;
            logic [15:0] ec;
            logic [31:0] ed;
            ev = (t == dep(k));
            ec = ev ? 16'h0C3A : 16'h0;
            ed = ev ? 32'hDEAD_BEEF : 32'h0;
            total++;
            if ({act_v(k), act_c(k), act_d(k)} !== {ev, ec, ed})
               $display("FAIL latency k=%0d t=%0d got v=%0b c=%h d=%h want v=%0b c=%h d=%h",
                        k, t, act_v(k), act_c(k), act_d(k), ev, ec, ed);
            else passed++;
         end
      end
   endtask

   task automatic test_stall();
      drive(1, 0, 0, 0, 16'h0, 32'h0);
      tick();
      drive(0, 0, 0, 1, 16'h1234, 32'h0000_1111);
      tick();
      for (int t = 1; t <= 4; t++) begin
         drive(0, 0, 1, 1, 16'h1234 + 16'(t * 16'h0101), 32'h0000_2000 + t);
         tick();
         total++;
         if (c0 !== 16'h1234 || d0 !== 32'h0000_1111 || v0 !== 1'b1)
            $display("FAIL stall_hold t=%0d got c=%h d=%h v=%0b want c=1234 d=00001111 v=1", t, c0, d0, v0);
         else passed++;
      end
      total++;
      if (s0 !== 16'd4 || b0 !== 16'd0)
         $display("FAIL stall_counts got sc=%0d bc=%0d want sc=4 bc=0", s0, b0);
      else passed++;
   endtask

   task automatic test_flush();
      drive(1, 0, 0, 0, 16'h0, 32'h0);
      tick();
      drive(0, 0, 0, 1, 16'h00FF, 32'h55);
      for (int t = 0; t < 4; t++) tick();
      drive(0, 1, 1, 1, 16'hBEEF, 32'h77);
      tick();
      for (int k = 0; k < NDUT; k++) begin
         logic [31:0] ed;
         ed = clr(k) ? 32'h0 : 32'h55;
         total++;
         if ({act_v(k), act_c(k), act_d(k), act_s(k), act_b(k)} !== {1'b0, 16'h0, ed, 16'd0, 16'd1})
            $display("FAIL flush_over_stall k=%0d got v=%0b c=%h d=%h sc=%0d bc=%0d want v=0 c=0 d=%h sc=0 bc=1",
                     k, act_v(k), act_c(k), act_d(k), act_s(k), act_b(k), ed);
         else passed++;
      end
   endtask

   task automatic test_invalid();
      drive(1, 0, 0, 0, 16'h0, 32'h0);
      tick();
      drive(0, 0, 0, 1, 16'h1234, 32'h1);
      tick();
      drive(0, 0, 0, 0, 16'hFFFF, 32'hA5A5_0001);
      tick();
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({act_v(k), act_c(k), act_d(k), act_b(k)} !== {1'b0, 16'h0, 32'hA5A5_0001, 16'd1})
            $display("FAIL invalid_input k=%0d got v=%0b c=%h d=%h bc=%0d want v=0 c=0 d=a5a50001 bc=1",
                     k, act_v(k), act_c(k), act_d(k), act_b(k));
         else passed++;
      end
   endtask

   task automatic test_saturation();
      drive(1, 0, 0, 0, 16'h0, 32'h0);
      tick();
      drive(0, 0, 1, 0, 16'h0, 32'h0);
      for (int t = 1; t <= 20; t++) begin
         tick();
         total++;
         if (s4 !== 4'((t > 15) ? 15 : t))
            $display("FAIL stall_saturation t=%0d got %0d want %0d", t, s4, (t > 15) ? 15 : t);
         else passed++;
      end
      total++;
      if (s0 !== 16'd20)
         $display("FAIL stall_wide_count got %0d want 20", s0);
      else passed++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 9) < 7), 16'($urandom), $urandom);
         tick();
         for (int k = 0; k < NDUT; k++) begin
            ent_t e;
            e = exp_out(k);
            total++;
            if ({act_v(k), act_c(k), act_d(k)} !== {e.v, e.c, e.d})
               $display("FAIL random_data k=%0d cyc=%0d got v=%0b c=%h d=%h want v=%0b c=%h d=%h",
                        k, n, act_v(k), act_c(k), act_d(k), e.v, e.c, e.d);
            else passed++;
            total++;
            if (act_s(k) !== 16'(msc[k]) || act_b(k) !== 16'(mbc[k]))
               $display("FAIL random_counts k=%0d cyc=%0d got sc=%0d bc=%0d want sc=%0d bc=%0d",
                        k, n, act_s(k), act_b(k), msc[k], mbc[k]);
            else passed++;
         end
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 16'h0, 32'h0);
      test_reset();
      test_latency();
      test_stall();
      test_flush();
      test_invalid();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
